// File: rtl/fnd_pkg.sv
// Shared register offsets and active-low 7-segment font constants for the FND scanner.
package fnd_pkg;

   localparam logic [4:0] FCR_OFF   = 5'h00;
   localparam logic [4:0] FDR_OFF   = 5'h04;
   localparam logic [4:0] FDP_OFF   = 5'h08;
   localparam logic [4:0] FDIV_OFF  = 5'h0C;
   localparam logic [4:0] FSTAT_OFF = 5'h10;
   localparam logic [4:0] FBRT_OFF  = 5'h14;

   // gfedcba, a segment is lit when its bit is 0
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/apb_fnd_scan_if.sv
// APB3 bus bundle between the peripheral bridge (master) and the FND scanner (slave).
interface apb_fnd_scan_if;
   logic [4:0]  PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/fnd_hex_decoder.sv
// Combinational hex nibble to active-low gfedcba segment pattern.
module fnd_hex_decoder
   import fnd_pkg::*;
(
   input  logic [3:0] hex_dat,
   output logic [6:0] seg_dat
);

   always_comb begin
      seg_dat = SEG_BLANK;
      case (hex_dat)
         4'h0: seg_dat = SEG_0;
         4'h1: seg_dat = SEG_1;
         4'h2: seg_dat = SEG_2;
         4'h3: seg_dat = SEG_3;
         4'h4: seg_dat = SEG_4;
         4'h5: seg_dat = SEG_5;
         4'h6: seg_dat = SEG_6;
         4'h7: seg_dat = SEG_7;
         4'h8: seg_dat = SEG_8;
         4'h9: seg_dat = SEG_9;
         4'hA: seg_dat = SEG_A;
         4'hB: seg_dat = SEG_B;
         4'hC: seg_dat = SEG_C;
         4'hD: seg_dat = SEG_D;
         4'hE: seg_dat = SEG_E;
         4'hF: seg_dat = SEG_F;
         default: seg_dat = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/apb_fnd_scan.sv
// Zero-wait APB3 slave scanning a common-anode 7-segment display; pins are registered one cycle behind state.
// FND_BRIGHT_EN adds the FBRT duty register that PWM-gates the active common.
module apb_fnd_scan
   import fnd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIV_W      = 16,
   parameter int DIV_RESET  = 49999
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   apb_fnd_scan_if.slave         apb,
   output logic [NUM_DIGITS-1:0] FND_comm,
   output logic [7:0]            FND_font
);

   localparam logic [2:0]       W_FCR    = FCR_OFF[4:2];
   localparam logic [2:0]       W_FDR    = FDR_OFF[4:2];
   localparam logic [2:0]       W_FDP    = FDP_OFF[4:2];
   localparam logic [2:0]       W_FDIV   = FDIV_OFF[4:2];
   localparam logic [2:0]       W_FSTAT  = FSTAT_OFF[4:2];
   localparam logic [2:0]       W_FBRT   = FBRT_OFF[4:2];
   localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0] FDIV_RST = DIV_W'(DIV_RESET);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   logic                    acc, wr, rd, mapped, tick, fdiv_wr, common_on;
   logic [2:0]              word;
   logic [31:0]             rdata;
   logic                    unused_bits;

   logic                    en_q, en_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;
   logic [4*NUM_DIGITS-1:0] fdr_q, fdr_d;
   logic [NUM_DIGITS-1:0]   fdp_q, fdp_d;
   logic [DIV_W-1:0]        fdiv_q, fdiv_d;
   logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
   logic [2:0]              idx_q, idx_d;
   logic [NUM_DIGITS-1:0]   comm_q, comm_d;
   logic [7:0]              font_q, font_d;

   logic [3:0]              cur_nib;
   logic                    cur_dp, cur_den;
   logic [6:0]              cur_seg;

`ifdef FND_BRIGHT_EN
   logic [3:0]              duty_q, duty_d;
   logic [3:0]              pwm_cnt_q, pwm_cnt_d;
`endif

   assign acc  = apb.PSEL & apb.PENABLE;
   assign wr   = acc & apb.PWRITE;
   assign rd   = acc & ~apb.PWRITE;
   assign word = apb.PADDR[4:2];

   // Byte lanes and the low address bits carry no meaning for this block
   assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

   always_comb begin
      mapped = 1'b0;
      case (word)
         W_FCR, W_FDR, W_FDP, W_FDIV, W_FSTAT: mapped = 1'b1;
`ifdef FND_BRIGHT_EN
         W_FBRT:                               mapped = 1'b1;
`endif
         default:                              mapped = 1'b0;
      endcase
   end

   always_comb begin
      en_d    = en_q;
      mask_d  = mask_q;
      fdr_d   = fdr_q;
      fdp_d   = fdp_q;
      fdiv_d  = fdiv_q;
      fdiv_wr = 1'b0;
`ifdef FND_BRIGHT_EN
      duty_d  = duty_q;
`endif
      if (wr) begin
         case (word)
            W_FCR: begin
               en_d   = apb.PWDATA[0];
               mask_d = apb.PWDATA[8 +: NUM_DIGITS];
            end
            W_FDR:   fdr_d = apb.PWDATA[4*NUM_DIGITS-1:0];
            W_FDP:   fdp_d = apb.PWDATA[NUM_DIGITS-1:0];
            W_FDIV: begin
               fdiv_d  = apb.PWDATA[DIV_W-1:0];
               fdiv_wr = 1'b1;
            end
`ifdef FND_BRIGHT_EN
            W_FBRT:  duty_d = apb.PWDATA[3:0];
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (word)
         W_FCR: begin
            rdata[0]              = en_q;
            rdata[8 +: NUM_DIGITS] = mask_q;
         end
         W_FDR:   rdata[4*NUM_DIGITS-1:0] = fdr_q;
         W_FDP:   rdata[NUM_DIGITS-1:0]   = fdp_q;
         W_FDIV:  rdata[DIV_W-1:0]        = fdiv_q;
         W_FSTAT: rdata[2:0]              = idx_q;
`ifdef FND_BRIGHT_EN
         W_FBRT:  rdata[3:0]              = duty_q;
`endif
         default: ;
      endcase
   end

   assign apb.PRDATA  = rd ? rdata : 32'h0;
   assign apb.PREADY  = acc;
   assign apb.PSLVERR = acc & ~mapped;

   // A divider write restarts the current slot so the new period takes effect cleanly
   always_comb begin
      tick      = (div_cnt_q == fdiv_q);
      div_cnt_d = (fdiv_wr || tick) ? '0 : div_cnt_q + DIV_ONE;
      idx_d     = idx_q;
      if (tick) idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
   end

   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      cur_den = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == 3'(i)) begin
            cur_nib = fdr_q[4*i +: 4];
            cur_dp  = fdp_q[i];
            cur_den = mask_q[i];
         end
      end
   end

   fnd_hex_decoder u_hex_decoder (
      .hex_dat (cur_nib),
      .seg_dat (cur_seg)
   );

`ifdef FND_BRIGHT_EN
   assign common_on = (pwm_cnt_q <= duty_q);
   assign pwm_cnt_d = pwm_cnt_q + 4'd1;
`else
   assign common_on = 1'b1;
`endif

   // Disabled digits still occupy their slot, only blanked, so duty per digit is constant
   always_comb begin
      comm_d = '1;
      font_d = {1'b1, SEG_BLANK};
      if (en_q && cur_den) begin
         font_d = {~cur_dp, cur_seg};
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) comm_d[i] = ~common_on;
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         en_q      <= 1'b0;
         mask_q    <= '1;
         fdr_q     <= '0;
         fdp_q     <= '0;
         fdiv_q    <= FDIV_RST;
         div_cnt_q <= '0;
         idx_q     <= 3'd0;
         comm_q    <= '1;
         font_q    <= 8'hFF;
`ifdef FND_BRIGHT_EN
         duty_q    <= 4'hF;
         pwm_cnt_q <= 4'h0;
`endif
      end else begin
         en_q      <= en_d;
         mask_q    <= mask_d;
         fdr_q     <= fdr_d;
         fdp_q     <= fdp_d;
         fdiv_q    <= fdiv_d;
         div_cnt_q <= div_cnt_d;
         idx_q     <= idx_d;
         comm_q    <= comm_d;
         font_q    <= font_d;
`ifdef FND_BRIGHT_EN
         duty_q    <= duty_d;
         pwm_cnt_q <= pwm_cnt_d;
`endif
      end
   end

   assign FND_comm = comm_q;
   assign FND_font = font_q;

endmodule
